spi_master_rx_fifo: RTL
=======================

# spi_master_rx_fifo

Receive-side buffer between the SPI receive shifter and the register/AXI read path. Accepts one 32-bit word per valid/ready handshake from the shifter, stores up to BUFFER_DEPTH words in order, and presents them to the read side through a second valid/ready handshake. Its ready output throttles the shifter: when the buffer is full, the shifter stops the SPI clock until space frees up.

## Interface
- DATA_WIDTH, 32, word width on both sides
- BUFFER_DEPTH, 8, number of storage entries; any value >= 2; need not be a power of two
- LOG_BUFFER_DEPTH, $clog2(BUFFER_DEPTH), derived; do not override
- clk  in  1  clock; all state changes on the rising edge
- rstn  in  1  reset, asynchronous, active-low
- clr_i  in  1  synchronous flush: empties the buffer on the next edge
- elements_o  out  LOG_BUFFER_DEPTH+1  current occupancy, 0..BUFFER_DEPTH
- data_i  in  DATA_WIDTH  write data from the receive shifter
- valid_i  in  1  write request
- ready_o  out  1  write side can accept a word (not full)
- data_o  out  DATA_WIDTH  oldest stored word
- valid_o  out  1  data_o is valid (not empty)
- ready_i  in  1  read side consumes data_o

## Operation
- State: write pointer, read pointer (each 0..BUFFER_DEPTH-1), occupancy counter (0..BUFFER_DEPTH), storage array.
- Push = valid_i && ready_o: write data_i to mem[wr_ptr]; wr_ptr advances.
- Pop = valid_o && ready_i: rd_ptr advances.
- Pointer wrap: a pointer at BUFFER_DEPTH-1 advances to 0. Use an explicit compare, not a natural overflow, so non-power-of-2 depths work.
- Occupancy update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, and both pointers advance
- ready_o = (elements != BUFFER_DEPTH). It is driven from registered state only and never depends on valid_i. This is required because the shifter drives valid combinationally from ready.
- valid_o = (elements != 0). data_o = mem[rd_ptr], combinational read.
- No fall-through: a word pushed into an empty buffer appears on valid_o one cycle later.
- When full, ready_o=0 blocks any write, even if a pop happens in the same cycle. Free space is visible on ready_o the cycle after the pop.
- When empty, valid_o=0 and data_o is don't-care. A push in this state is accepted normally.
- clr_i: on the next edge, pointers and occupancy go to 0. clr_i takes priority over a simultaneous push or pop; a word presented that cycle is dropped. Storage contents are not cleared.
- Write-side contract: the producer holds data_i stable while valid_i=1 and ready_o=0. The FIFO does not check this.

## Timing
- Reset values: elements_o=0, ready_o=1, valid_o=0, both pointers 0. data_o is undefined: storage is not reset, and there is no reset on the memory array.
- Write-to-read latency: 1 cycle.
- Sustained throughput: 1 word/cycle with simultaneous push and pop at any occupancy from 1 to BUFFER_DEPTH-1.
- Full to not-full: ready_o rises in the cycle after the pop edge.
- Reset asserted mid-operation: all state returns to its reset values immediately (asynchronous). Buffered words are lost.

## Structure
- Single module, no sub-modules. The storage is a flop array indexed by rd_ptr/wr_ptr.
- Constants: none are shared. LOG_BUFFER_DEPTH is a derived parameter.
- The same module is instantiated as the transmit-side buffer, so it must contain no receive-specific logic.

## Test plan
- Reset, then idle: after rstn rises, elements_o=0, ready_o=1, valid_o=0, held for 10 cycles.
- Fill and drain, DEPTH=8:
  - push 0x1..0x8 with ready_i=0 -> ready_o=0 after the 8th push; elements_o=8
  - a 9th valid_i with 0xDEAD is not accepted
  - set ready_i=1 -> data_o reads 0x1..0x8 in order, one per cycle; valid_o=0 after the last word
- Simultaneous push/pop:
  - preload 3 words, then push and pop every cycle for 20 cycles -> elements_o stays 3; output is the input sequence delayed by 3 words
  - repeat at occupancy 8: a push with a same-cycle pop is refused (ready_o=0); ready_o=1 on the next cycle
- Wrap with non-power-of-2 depth (DEPTH=5): push and pop 23 words in bursts -> order is preserved across pointer wrap; elements_o never exceeds 5.
- clr_i with 4 words stored and a push in the same cycle -> next cycle elements_o=0, valid_o=0; the pushed word is not read out later.
- Asynchronous reset asserted mid-burst with 6 words stored -> elements_o=0 and valid_o=0 without waiting for a clock edge; the first push after release is read out first.

Source files
------------

// File: rtl/spi_master_rx_fifo_pkg.sv
// Shared helpers for the SPI receive/transmit word buffer.
// Pointer wrap uses an explicit compare so any depth works.
package spi_master_rx_fifo_pkg;

   function automatic int unsigned wrap_inc(
      input int unsigned ptr,
      input int unsigned depth
   );
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/spi_master_rx_fifo.sv
// Word buffer between the SPI shifter and the read path.
// ready_o comes from registered occupancy only, never from valid_i.
module spi_master_rx_fifo
   import spi_master_rx_fifo_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int BUFFER_DEPTH     = 8,
   parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      clr_i,
   output logic [LOG_BUFFER_DEPTH:0] elements_o,
   input  logic [DATA_WIDTH-1:0]     data_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   output logic [DATA_WIDTH-1:0]     data_o,
   output logic                      valid_o,
   input  logic                      ready_i
);

   localparam logic [LOG_BUFFER_DEPTH:0] FULL =
      BUFFER_DEPTH[LOG_BUFFER_DEPTH:0];

   logic [LOG_BUFFER_DEPTH-1:0] wr_ptr;
   logic [LOG_BUFFER_DEPTH-1:0] rd_ptr;
   logic [LOG_BUFFER_DEPTH:0]   elements;
   logic [DATA_WIDTH-1:0]       mem [BUFFER_DEPTH];
   logic                        push;
   logic                        pop;

   assign ready_o    = (elements != FULL);
   assign valid_o    = (elements != '0);
   assign elements_o = elements;
   assign data_o     = mem[rd_ptr];
   assign push       = valid_i & ready_o;
   assign pop        = valid_o & ready_i;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         elements <= '0;
      end else if (clr_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         elements <= '0;
      end else begin
         if (push)
            wr_ptr <= LOG_BUFFER_DEPTH'(
               wrap_inc(32'(wr_ptr), BUFFER_DEPTH));
         if (pop)
            rd_ptr <= LOG_BUFFER_DEPTH'(
               wrap_inc(32'(rd_ptr), BUFFER_DEPTH));
         case ({push, pop})
            2'b10:   elements <= elements + 1'b1;
            2'b01:   elements <= elements - 1'b1;
            default: elements <= elements;
         endcase
      end
   end

   // Storage is intentionally left unreset; a flush only moves pointers.
   always_ff @(posedge clk) begin
      if (push && !clr_i)
         mem[wr_ptr] <= data_i;
   end

endmodule
